// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, blank and sync strobes
// and blanked RGB, all advanced by a pixel clock-enable on clk.
module video_timing_gen #(
   parameter int H_TOTAL     = 396,
   parameter int H_ACT_START = 24,
   parameter int H_ACT_END   = 264,
   parameter int HS_START    = 320,
   parameter int HS_WIDTH    = 32,
   parameter int V_TOTAL     = 256,
   parameter int VB_START    = 223,
   parameter int VB_END      = 255,
   parameter int VS_START    = 226,
   parameter int VS_WIDTH    = 6,
   parameter int RGB_W       = 12,
   parameter int HOFFS_W     = 5,
   parameter int VOFFS_W     = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ce_pix,
   input  logic signed [HOFFS_W-1:0] hoffs,
   input  logic signed [VOFFS_W-1:0] voffs,
   input  logic [RGB_W-1:0]          rgb_in,
   output logic [8:0]                hpos,
   output logic [8:0]                vpos,
   output logic [RGB_W-1:0]          rgb_out,
   output logic                      hblank,
   output logic                      vblank,
   output logic                      hsync,
   output logic                      vsync,
   output logic                      line_start,
   output logic                      frame_start
);

   if (H_TOTAL > 512 || V_TOTAL > 512 ||
       HS_WIDTH >= H_TOTAL || VS_WIDTH >= V_TOTAL ||
       H_ACT_START >= H_ACT_END || H_ACT_END > H_TOTAL) begin : g_bad_params
      $fatal(1, "video_timing_gen: illegal timing parameters");
   end

   localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
   localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
   localparam logic [8:0] HA_OFS = 9'(H_ACT_START);
   localparam logic [9:0] H_T    = 10'(H_TOTAL);
   localparam logic [9:0] V_T    = 10'(V_TOTAL);
   localparam logic [9:0] HA_S   = 10'(H_ACT_START);
   localparam logic [9:0] HA_E   = 10'(H_ACT_END);
   localparam logic [9:0] VB_S   = 10'(VB_START);
   localparam logic [9:0] VB_E   = 10'(VB_END);

   logic [8:0]                hcnt;
   logic [8:0]                vcnt;
   logic signed [HOFFS_W-1:0] hoffs_l;
   logic signed [VOFFS_W-1:0] voffs_l;
   logic [9:0]                hs_b, hs_e, vs_b, vs_e;
   logic [9:0]                hx, vx;
   logic                      h_wrap, v_wrap;

   // Offsets are small, so one correction brings the sum back into 0..t-1.
   function automatic logic [9:0] mod_wrap(
      input logic signed [10:0] s,
      input logic [9:0]         t
   );
      logic signed [10:0] ts;
      ts = signed'({1'b0, t});
      if (s < 0)
         return 10'(s + ts);
      else if (s >= ts)
         return 10'(s - ts);
      else
         return 10'(s);
   endfunction

   function automatic logic in_win(
      input logic [9:0] x,
      input logic [9:0] b,
      input logic [9:0] e
   );
      return (b <= e) ? (x >= b && x < e) : (x >= b || x < e);
   endfunction

   assign hs_b = mod_wrap(11'(HS_START) + 11'(hoffs_l), H_T);
   assign hs_e = mod_wrap(signed'({1'b0, hs_b}) + 11'(HS_WIDTH), H_T);
   assign vs_b = mod_wrap(11'(VS_START) + 11'(voffs_l), V_T);
   assign vs_e = mod_wrap(signed'({1'b0, vs_b}) + 11'(VS_WIDTH), V_T);

   assign hx     = {1'b0, hcnt};
   assign vx     = {1'b0, vcnt};
   assign h_wrap = (hcnt == H_LAST);
   assign v_wrap = (vcnt == V_LAST);

   assign hpos = hcnt - HA_OFS;
   assign vpos = vcnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt        <= '0;
         vcnt        <= '0;
         hoffs_l     <= '0;
         voffs_l     <= '0;
         rgb_out     <= '0;
         hblank      <= 1'b0;
         vblank      <= 1'b0;
         hsync       <= 1'b0;
         vsync       <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (ce_pix) begin
            if (h_wrap) begin
               hcnt <= '0;
               vcnt <= v_wrap ? 9'd0 : vcnt + 9'd1;
            end else begin
               hcnt <= hcnt + 9'd1;
            end
            if (h_wrap && v_wrap) begin
               hoffs_l <= hoffs;
               voffs_l <= voffs;
            end
            // Blank is the registered value, so RGB trails blank by a pixel.
            rgb_out     <= (hblank || vblank) ? '0 : rgb_in;
            hblank      <= (hx < HA_S) || (hx >= HA_E);
            vblank      <= (vx >= VB_S) && (vx < VB_E);
            hsync       <= in_win(hx, hs_b, hs_e);
            vsync       <= in_win(vx, vs_b, vs_e);
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
         end
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two scaled-down instances checked every clk
// against a pixel-index reference model.
module tb_video_timing_gen;

   localparam int HT    = 40;
   localparam int HAS   = 4;
   localparam int HAE   = 30;
   localparam int HSS_A = 32;
   localparam int HSS_B = 38;
   localparam int HSW   = 4;
   localparam int VT    = 20;
   localparam int VBS   = 15;
   localparam int VBE_A = 19;
   localparam int VBE_B = 20;
   localparam int VSS   = 16;
   localparam int VSW   = 2;

   logic              clk;
   logic              reset;
   logic              ce_pix;
   logic signed [4:0] hoffs;
   logic signed [3:0] voffs;
   logic [11:0]       rgb_in;

   logic [8:0]  hpos_a, vpos_a, hpos_b, vpos_b;
   logic [11:0] rgb_a, rgb_b;
   logic        hb_a, vb_a, hs_a, vs_a, ls_a, fs_a;
   logic        hb_b, vb_b, hs_b, vs_b, ls_b, fs_b;

   video_timing_gen #(
      .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACT_END(HAE),
      .HS_START(HSS_A), .HS_WIDTH(HSW),
      .V_TOTAL(VT), .VB_START(VBS), .VB_END(VBE_A),
      .VS_START(VSS), .VS_WIDTH(VSW),
      .RGB_W(12), .HOFFS_W(5), .VOFFS_W(4)
   ) u_dut (
      .clk(clk), .reset(reset), .ce_pix(ce_pix),
      .hoffs(hoffs), .voffs(voffs), .rgb_in(rgb_in),
      .hpos(hpos_a), .vpos(vpos_a), .rgb_out(rgb_a),
      .hblank(hb_a), .vblank(vb_a), .hsync(hs_a), .vsync(vs_a),
      .line_start(ls_a), .frame_start(fs_a)
   );

   video_timing_gen #(
      .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACT_END(HAE),
      .HS_START(HSS_B), .HS_WIDTH(HSW),
      .V_TOTAL(VT), .VB_START(VBS), .VB_END(VBE_B),
      .VS_START(VSS), .VS_WIDTH(VSW),
      .RGB_W(12), .HOFFS_W(5), .VOFFS_W(4)
   ) u_wrap (
      .clk(clk), .reset(reset), .ce_pix(ce_pix),
      .hoffs(hoffs), .voffs(voffs), .rgb_in(rgb_in),
      .hpos(hpos_b), .vpos(vpos_b), .rgb_out(rgb_b),
      .hblank(hb_b), .vblank(vb_b), .hsync(hs_b), .vsync(vs_b),
      .line_start(ls_b), .frame_start(fs_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int pix, hl, vl;
   int frames_exp, frames_dut;
   logic e_hb, e_vb, e_vb2, e_hs, e_hs2, e_vs, e_ls, e_fs;
   logic [11:0] e_rgb, e_rgb2;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Position of x inside a window of length w starting at start, mod t.
   function automatic bit in_window(int x, int start, int w, int t);
      int d;
      d = ((x - start) % t + t) % t;
      return d < w;
   endfunction

   task automatic model_step(input bit rst, input bit ce);
      int h, v;
      if (rst) begin
         pix = 0; hl = 0; vl = 0;
         e_hb = 0; e_vb = 0; e_vb2 = 0; e_hs = 0; e_hs2 = 0;
         e_vs = 0; e_ls = 0; e_fs = 0; e_rgb = 0; e_rgb2 = 0;
         return;
      end
      e_ls = 0;
      e_fs = 0;
      if (!ce) return;
      h = pix % HT;
      v = pix / HT;
      e_rgb  = (e_hb || e_vb)  ? 12'h000 : rgb_in;
      e_rgb2 = (e_hb || e_vb2) ? 12'h000 : rgb_in;
      e_hb   = (h < HAS) || (h >= HAE);
      e_vb   = (v >= VBS) && (v < VBE_A);
      e_vb2  = (v >= VBS) && (v < VBE_B);
      e_hs   = in_window(h, HSS_A + hl, HSW, HT);
      e_hs2  = in_window(h, HSS_B + hl, HSW, HT);
      e_vs   = in_window(v, VSS + vl, VSW, VT);
      e_ls   = (h == HT - 1);
      e_fs   = (pix == HT * VT - 1);
      if (e_fs) begin
         hl = hoffs;
         vl = voffs;
         frames_exp++;
      end
      pix = (pix + 1) % (HT * VT);
   endtask

   task automatic check_all();
      int h, v;
      h = pix % HT;
      v = pix / HT;
      chk("hpos",   32'(hpos_a), 32'(((h - HAS) % 512 + 512) % 512));
      chk("vpos",   32'(vpos_a), 32'(v));
      chk("hblank", 32'(hb_a),   32'(e_hb));
      chk("vblank", 32'(vb_a),   32'(e_vb));
      chk("hsync",  32'(hs_a),   32'(e_hs));
      chk("vsync",  32'(vs_a),   32'(e_vs));
      chk("rgb",    32'(rgb_a),  32'(e_rgb));
      chk("line",   32'(ls_a),   32'(e_ls));
      chk("frame",  32'(fs_a),   32'(e_fs));
      chk("w_vblank", 32'(vb_b),  32'(e_vb2));
      chk("w_hsync",  32'(hs_b),  32'(e_hs2));
      chk("w_rgb",    32'(rgb_b), 32'(e_rgb2));
      chk("w_hpos",   32'(hpos_b), 32'(hpos_a));
      chk("w_frame",  32'(fs_b),  32'(e_fs));
      if (fs_a === 1'b1) frames_dut++;
   endtask

   task automatic cycle(input bit r, input bit c);
      reset  = r;
      ce_pix = c;
      model_step(r, c);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      int n;
      frames_exp = 0;
      frames_dut = 0;
      reset  = 1'b1;
      ce_pix = 1'b0;
      hoffs  = '0;
      voffs  = '0;
      rgb_in = 12'hFFF;

      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);

      // Two frames, ce every 8th clk, constant white input.
      for (int i = 0; i < 2 * HT * VT * 8; i++)
         cycle(1'b0, (i % 8) == 7);

      // Move mid-frame to line 5, then shift syncs by -16 / +7.
      n = 0;
      while (pix / HT != 5 && n < HT * VT * 2) begin
         cycle(1'b0, 1'b1);
         n++;
      end
      chk("seek_v5", 32'(pix / HT), 32'd5);
      hoffs = 5'b10000;
      voffs = 4'sd7;
      for (int i = 0; i < 2 * HT * VT * 2; i++)
         cycle(1'b0, (i % 2) == 1);

      // Outputs must hold with ce low.
      for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0);

      // Random ce, colour and mid-frame offset changes.
      for (int i = 0; i < 4000; i++) begin
         rgb_in = 12'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            hoffs = 5'($urandom_range(0, 31));
            voffs = 4'($urandom_range(0, 15));
         end
         cycle(1'b0, $urandom_range(0, 2) != 0);
      end

      // Reset for one clk with ce high at a known mid-frame position.
      n = 0;
      while (!(pix % HT == 20 && pix / HT == 10) && n < HT * VT * 2) begin
         cycle(1'b0, 1'b1);
         n++;
      end
      chk("seek_rst", 32'(pix), 32'(10 * HT + 20));
      cycle(1'b1, 1'b1);
      chk("rst_hpos", 32'(hpos_a), 32'(512 - HAS));
      chk("rst_vpos", 32'(vpos_a), 32'd0);
      chk("rst_frame", 32'(fs_a), 32'd0);

      for (int i = 0; i < HT * VT + 200; i++) begin
         rgb_in = 12'($urandom);
         cycle(1'b0, $urandom_range(0, 1) == 1);
      end

      chk("frames", 32'(frames_dut), 32'(frames_exp));
      chk("frames_nz", 32'(frames_exp > 4), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator for arcade cores; successor to the fixed 396x256 per-core timing block.
- Runs on the system clock with a pixel clock-enable, not a derived pixel clock.
- Produces pixel/line counters for the game core, blank and sync strobes for the video pipeline, and blanked, registered RGB.
- Adds signed H/V sync offsets latched once per frame, wrap-safe sync windows, line/frame start pulses, and a configurable V total.

Parameters:
- H_TOTAL, 396, pixels per line (counter 0..H_TOTAL-1)
- H_ACT_START, 24, first active hcnt; also subtracted from hcnt to form hpos
- H_ACT_END, 264, first hblank hcnt after active region
- HS_START, 320, nominal hsync start hcnt
- HS_WIDTH, 32, hsync length in pixels
- V_TOTAL, 256, lines per frame (counter 0..V_TOTAL-1)
- VB_START, 223, first vblank line
- VB_END, 255, first active line after vblank; may equal V_TOTAL
- VS_START, 226, nominal vsync start line
- VS_WIDTH, 6, vsync length in lines
- RGB_W, 12, pixel colour width
- HOFFS_W, 5, signed h-offset width
- VOFFS_W, 4, signed v-offset width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce_pix  in  1  pixel clock enable; all timing state advances only when high
- hoffs  in  HOFFS_W  signed hsync shift in pixels
- voffs  in  VOFFS_W  signed vsync shift in lines
- rgb_in  in  RGB_W  pixel colour from the game core
- hpos  out  9  hcnt - H_ACT_START, modulo 512, combinational from hcnt
- vpos  out  9  vcnt, zero-extended
- rgb_out  out  RGB_W  registered colour, forced to 0 during blank
- hblank  out  1  registered horizontal blank
- vblank  out  1  registered vertical blank
- hsync  out  1  registered hsync, active high
- vsync  out  1  registered vsync, active high
- line_start  out  1  one-clk pulse on the ce_pix where hcnt wraps to 0
- frame_start  out  1  one-clk pulse on the ce_pix where hcnt and vcnt both wrap to 0

Behaviour:
Reset values:
- hcnt=0, vcnt=0
- rgb_out=0, hblank=0, vblank=0, hsync=0, vsync=0, line_start=0, frame_start=0
- latched offsets = 0

Outputs hold when ce_pix=0:
- line_start and frame_start are cleared on any clk where ce_pix=0; they are never high for more than one clk.

On each ce_pix, counters:
- if hcnt==H_TOTAL-1: hcnt<=0; vcnt <= (vcnt==V_TOTAL-1) ? 0 : vcnt+1
- else hcnt<=hcnt+1
- vcnt wraps at V_TOTAL, not at the counter width.

On each ce_pix, offsets:
- on the frame wrap (hcnt==H_TOTAL-1 and vcnt==V_TOTAL-1), hoffs and voffs are sampled into hoffs_l and voffs_l
- mid-frame changes on hoffs/voffs have no effect until the next frame.

Sync windows, computed with sign extension:
- hs_b = (HS_START + hoffs_l) mod H_TOTAL; hs_e = (hs_b + HS_WIDTH) mod H_TOTAL
- vs_b and vs_e likewise with VS_START, voffs_l, VS_WIDTH, V_TOTAL
- in_win(x,b,e) = (b<=e) ? (x>=b && x<e) : (x>=b || x<e), so windows may straddle the wrap point.

Registered strobes, updated on ce_pix from pre-increment counter values (one pixel of latency, intentional and matching legacy timing):
- hblank <= hcnt<H_ACT_START || hcnt>=H_ACT_END
- vblank <= vcnt>=VB_START && vcnt<VB_END
- hsync <= in_win(hcnt, hs_b, hs_e)
- vsync <= in_win(vcnt, vs_b, vs_e)
- rgb_out <= (hblank||vblank) ? 0 : rgb_in, using the already-registered blank, so RGB lags blank by one further pixel.

Pulses, registered:
- line_start <= ce_pix && hcnt==H_TOTAL-1
- frame_start <= ce_pix && hcnt==H_TOTAL-1 && vcnt==V_TOTAL-1

Reset mid-frame:
- counters return to 0 on the next clk regardless of ce_pix
- pulses do not fire on reset.

Parameter legality (checked by elaboration assertion):
- H_TOTAL<=512, V_TOTAL<=512
- HS_WIDTH<H_TOTAL, VS_WIDTH<V_TOTAL
- H_ACT_START<H_ACT_END<=H_TOTAL

Test Plan:
- Defaults, offsets 0, ce_pix every 8th clk, run 2 frames:
  - 396*256 ce per frame_start
  - hsync high for hcnt 320..351 (32 ce)
  - vsync lines 226..231
  - vblank lines 223..254
  - hpos=0 at hcnt=24
- hoffs=-16 (5'b10000), voffs=+7:
  - first frame unchanged
  - after next frame_start, hsync spans hcnt 304..335 and vsync spans lines 233..238
- HS_START=380, HS_WIDTH=32:
  - hsync high for hcnt 380..395 and 0..15 (wrap window), total 32 ce per line
- Change hoffs at vcnt=100:
  - hsync position unchanged until the first line after frame_start.
- Assert reset for 1 clk at hcnt=200, vcnt=150:
  - next clk hcnt=0, vcnt=0, all outputs 0, no frame_start pulse.
- rgb_in=12'hFFF constant:
  - rgb_out=0 whenever registered hblank or vblank was set on the prior ce
  - rgb_out=FFF elsewhere
  - ce_pix held low for 100 clks → all outputs frozen.
